d_fifo_drain_arbiter: RTL and testbench
=======================================

Name: d_fifo_drain_arbiter

Overview:
- Downstream consumer of the full-logic transmit path.
- Drains the two destination FIFOs (D0, D1) round-robin and merges their words into one output stream tagged with the source FIFO.
- Gates draining on the full-logic active state; counts words delivered per destination.
- Absorbs the FIFOs' 1-cycle registered read latency and sink backpressure through a 2-entry output buffer.

Parameters:
- data_width, 6, width of FIFO words and data_out.
- cnt_width, 8, width of the per-destination delivered-word counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- active_in  in  1  active_out from full-logic FSM; new pops allowed only when 1.
- empty_fifo_D0  in  1  D0 FIFO empty; reflects occupancy after the previous edge's pop.
- empty_fifo_D1  in  1  D1 FIFO empty, same timing.
- data_out_D0  in  data_width  D0 FIFO read data, valid the cycle after D0_pop.
- data_out_D1  in  data_width  D1 FIFO read data, valid the cycle after D1_pop.
- D0_pop  out  1  pop request to D0 FIFO.
- D1_pop  out  1  pop request to D1 FIFO.
- sink_ready  in  1  downstream accepts data_out this cycle.
- valid_out  out  1  data_out/src_out hold a word.
- data_out  out  data_width  head word of output buffer.
- src_out  out  1  0 = word came from D0, 1 = from D1.
- cnt_D0  out  cnt_width  words delivered from D0.
- cnt_D1  out  cnt_width  words delivered from D1.
- idle_out  out  1  nothing pending anywhere.

Behaviour:
- Reset: D0_pop=D1_pop=0 (forced combinationally while reset=1); buffer empty; valid_out=0; data_out=0; src_out=0; cnt_D0=cnt_D1=0; last_grant=1, so D0 wins first; pend_valid=0; idle_out=1 once reset releases with FIFOs empty.
- Pop rule: at most one pop per cycle.
  - A pop is allowed when active_in=1, the target FIFO is not empty, and occ + pend_valid − xfer < 2.
  - occ is buffer occupancy (0..2); xfer = valid_out & sink_ready.
- Arbitration:
  - Both FIFOs non-empty: grant the FIFO not granted last.
  - One non-empty: grant it; back-to-back pops of the same FIFO are allowed.
  - last_grant updates only on an actual pop.
- Capture: a pop in cycle N sets pend_valid and pend_src at edge N.
  - In cycle N+1, data_out_D[pend_src] is written into the buffer at the tail.
- Latency: pop in cycle N → valid_out in cycle N+2 if the buffer was empty. Throughput is 1 word/cycle with sink_ready held at 1.
- Output buffer: 2-entry FIFO of {src, data}.
  - valid_out = occ≠0; data_out/src_out show the head; data_out holds its value when the buffer is empty.
  - Simultaneous write and xfer is legal at occ=1 and occ=2; occ stays the same.
- Counters: on xfer, increment cnt_D[src_out]; wrap modulo 2^cnt_width (255→0), no saturation.
- active_in falling: no new pops from that cycle; an in-flight pend capture still completes; the buffer keeps draining to the sink.
- FSM, state register separate from the datapath:
  - IDLE: occ=0, pend_valid=0. Go to DRAIN when active_in & any FIFO non-empty.
  - DRAIN: popping allowed. Go to STALL when the space check fails because occ + pend_valid ≥ 2 without xfer. Go to IDLE when nothing is pending and (active_in=0 or both FIFOs empty).
  - STALL: no pops. Go back to DRAIN when space frees.
  - idle_out = (state==IDLE).
- Reset mid-operation: an in-flight pend and buffered words are discarded; FIFOs are not re-read.
- Illegal state encoding: next state is IDLE.

Decomposition:
- Shared package holds:
  - FSM state typedef: ST_IDLE, ST_DRAIN, ST_STALL.
  - Source-select constants SRC_D0=0, SRC_D1=1.
  - Default widths DATA_W=6, CNT_W=8.
- One sub-module: drain_out_buffer (2-entry synchronous FIFO with simultaneous push/pop, occ output).
- Arbiter, FSM and counters stay in the top module.

Test Plan:
- Reset then single word: D0 holds 6'b000100, D1 empty, active_in=1, sink_ready=1 → D0_pop for 1 cycle; 2 cycles later valid_out=1, data_out=6'b000100, src_out=0; cnt_D0=1; idle_out returns to 1.
- Round-robin: D0={0x05,0x36}, D1={0x0E,0x22}, both non-empty → pop order D0,D1,D0,D1; output 0x05,0x0E,0x36,0x22 with src 0,1,0,1; cnt_D0=cnt_D1=2.
- Backpressure: 4 words in D1, sink_ready=0 → exactly 2 pops then STALL, valid_out=1 holding the first word. Raise sink_ready → remaining 2 words delivered in order, no loss or duplication.
- Gating: active_in=0 with both FIFOs non-empty → no pops, idle_out=1. Drop active_in the cycle after a pop → that word is still delivered and no further pops occur.
- Counter wrap: cnt_width=8, deliver 257 words from D0 → cnt_D0=1, cnt_D1=0.
- Reset mid-stream: assert reset with occ=2 and pend_valid=1 → next cycle valid_out=0, counters 0, pops 0, state IDLE.

Source files
------------

// File: rtl/d_fifo_drain_arbiter_pkg.sv
// Shared types and defaults for the destination-FIFO drain arbiter.
package d_fifo_drain_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned CNT_W  = 8;

endpackage

// File: rtl/d_fifo_drain_arbiter_buffer.sv
// Two-entry output FIFO with simultaneous push/pop; head register holds its
// last value when the buffer drains empty.
module drain_out_buffer #(
  parameter int unsigned width = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [width-1:0] head,
  output logic [1:0]       occ
);

  logic [width-1:0] head_q;
  logic [width-1:0] tail_q;
  logic [1:0]       occ_q;
  logic             pop_eff;
  logic             push_eff;

  assign pop_eff  = pop & (occ_q != 2'd0);
  assign push_eff = push & ((occ_q != 2'd2) | pop_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ_q != 2'd0);
  assign head  = head_q;
  assign occ   = occ_q;

endmodule

// File: rtl/d_fifo_drain_arbiter.sv
// Round-robin drain of destination FIFOs D0/D1 into one tagged output stream,
// gated by the full-logic active state, with per-destination delivery counters.
module d_fifo_drain_arbiter
  import d_fifo_drain_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_W,
  parameter int unsigned cnt_width  = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic [data_width-1:0] data_out_D0,
  input  logic [data_width-1:0] data_out_D1,
  output logic                  D0_pop,
  output logic                  D1_pop,
  input  logic                  sink_ready,
  output logic                  valid_out,
  output logic [data_width-1:0] data_out,
  output logic                  src_out,
  output logic [cnt_width-1:0]  cnt_D0,
  output logic [cnt_width-1:0]  cnt_D1,
  output logic                  idle_out
);

  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                pend_valid;
  logic                pend_src;
  logic [1:0]          occ;
  logic [2:0]          inflight;
  logic                xfer;
  logic                space_ok;
  logic                full_hold;
  logic                any_ne;
  logic                both_ne;
  logic                grant_d1;
  logic                pop_ok;
  logic [data_width:0] buf_head;

  assign xfer     = valid_out & sink_ready;
  // occ + pend_valid - xfer < 2, kept unsigned
  assign inflight  = {1'b0, occ} + {2'b00, pend_valid};
  assign space_ok  = (inflight < 3'd2) || ((inflight == 3'd2) && xfer);
  assign full_hold = (inflight >= 3'd2) && !xfer;

  assign any_ne   = !empty_fifo_D0 | !empty_fifo_D1;
  assign both_ne  = !empty_fifo_D0 & !empty_fifo_D1;
  assign grant_d1 = both_ne ? ~last_grant : empty_fifo_D0;
  assign pop_ok   = !reset & active_in & any_ne & space_ok & (state != ST_STALL);
  assign D0_pop   = pop_ok & (grant_d1 == SRC_D0);
  assign D1_pop   = pop_ok & (grant_d1 == SRC_D1);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_D1;
      pend_valid <= 1'b0;
      pend_src   <= SRC_D0;
      cnt_D0     <= '0;
      cnt_D1     <= '0;
    end else begin
      pend_valid <= pop_ok;
      if (pop_ok) begin
        last_grant <= grant_d1;
        pend_src   <= grant_d1;
      end
      if (xfer) begin
        if (src_out == SRC_D1) cnt_D1 <= cnt_D1 + CNT_ONE;
        else                   cnt_D0 <= cnt_D0 + CNT_ONE;
      end
    end
  end

  drain_out_buffer #(.width(data_width + 1)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_valid),
    .push_data ({pend_src, (pend_src == SRC_D1) ? data_out_D1 : data_out_D0}),
    .pop       (xfer),
    .valid     (valid_out),
    .head      (buf_head),
    .occ       (occ)
  );

  assign data_out = buf_head[data_width-1:0];
  assign src_out  = buf_head[data_width];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (active_in && any_ne) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (full_hold)
          state_nxt = ST_STALL;
        else if ((occ == 2'd0) && !pend_valid && (!active_in || !any_ne))
          state_nxt = ST_IDLE;
      end
      ST_STALL: if (!full_hold) state_nxt = ST_DRAIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign idle_out = (state == ST_IDLE);

endmodule

// File: tb/tb_d_fifo_drain_arbiter.sv
// Bench for d_fifo_drain_arbiter: FIFO models plus a queue-based model of the
// in-flight words, delivered stream and counters.
module tb_d_fifo_drain_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       active_in;
  logic       empty_fifo_D0;
  logic       empty_fifo_D1;
  logic [5:0] data_out_D0;
  logic [5:0] data_out_D1;
  logic       D0_pop;
  logic       D1_pop;
  logic       sink_ready;
  logic       valid_out;
  logic [5:0] data_out;
  logic       src_out;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       idle_out;

  d_fifo_drain_arbiter #(.data_width(6), .cnt_width(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .active_in     (active_in),
    .empty_fifo_D0 (empty_fifo_D0),
    .empty_fifo_D1 (empty_fifo_D1),
    .data_out_D0   (data_out_D0),
    .data_out_D1   (data_out_D1),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .sink_ready    (sink_ready),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .src_out       (src_out),
    .cnt_D0        (cnt_D0),
    .cnt_D1        (cnt_D1),
    .idle_out      (idle_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [6:0] mbuf[$];
  logic [6:0] mpend;
  logic       mpend_v;
  logic       mlast;
  logic [7:0] mcnt0;
  logic [7:0] mcnt1;
  logic [5:0] last_data;
  logic       pop_log[$];
  logic [6:0] deliv_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mbuf.delete();
    mpend_v   = 1'b0;
    mpend     = '0;
    mlast     = 1'b1;
    mcnt0     = '0;
    mcnt1     = '0;
    last_data = '0;
  endtask

  task automatic push0(input logic [5:0] w);
    q0.push_back(w);
    empty_fifo_D0 = 1'b0;
  endtask

  task automatic push1(input logic [5:0] w);
    q1.push_back(w);
    empty_fifo_D1 = 1'b0;
  endtask

  // One clock: check outputs against the model, take the edge, apply pops.
  task automatic cycle();
    logic       p0, p1, xf;
    logic [6:0] w;
    int         infl;
    #1;
    p0   = D0_pop;
    p1   = D1_pop;
    xf   = (mbuf.size() != 0) && sink_ready;
    infl = mbuf.size() + (mpend_v ? 1 : 0);
    if (reset) begin
      chk("rst_pops", {30'd0, p0, p1}, 0);
    end else begin
      chk("valid_out", valid_out, mbuf.size() != 0);
      if (mbuf.size() != 0) chk("head", {src_out, data_out}, mbuf[0]);
      else                  chk("data_hold", data_out, last_data);
      chk("cnt_D0", cnt_D0, mcnt0);
      chk("cnt_D1", cnt_D1, mcnt1);
      if (p0 || p1) begin
        chk("one_pop", p0 & p1, 0);
        chk("pop_active", active_in, 1);
        chk("pop_space", (infl - (xf ? 1 : 0)) < 2, 1);
        if (!empty_fifo_D0 && !empty_fifo_D1) chk("round_robin", p1, !mlast);
        else if (p0)                          chk("pop_empty_D0", empty_fifo_D0, 0);
        else                                  chk("pop_empty_D1", empty_fifo_D1, 0);
      end
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() != 0) data_out_D0 = q0.pop_front();
    if (p1 && q1.size() != 0) data_out_D1 = q1.pop_front();
    if (reset) begin
      model_clear();
    end else begin
      if (xf) begin
        w = mbuf.pop_front();
        deliv_log.push_back(w);
        if (w[6]) mcnt1++;
        else      mcnt0++;
      end
      if (mpend_v) mbuf.push_back(mpend);
      mpend_v = p0 | p1;
      if (p0) begin
        mpend = {1'b0, data_out_D0};
        mlast = 1'b0;
        pop_log.push_back(1'b0);
      end else if (p1) begin
        mpend = {1'b1, data_out_D1};
        mlast = 1'b1;
        pop_log.push_back(1'b1);
      end
      if (mbuf.size() != 0) last_data = mbuf[0][5:0];
    end
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    active_in  = 1'b1;
    sink_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && mbuf.size() == 0 && !mpend_v) break;
      cycle();
    end
    chk("drain_done", (q0.size() == 0 && q1.size() == 0 && mbuf.size() == 0 && !mpend_v), 1);
    cycle();
    cycle();
    chk("drain_idle", idle_out, 1);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    deliv_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] exp_rr[4];
    logic [6:0] exp_bp[4];
    reset         = 1'b1;
    active_in     = 1'b0;
    sink_ready    = 1'b1;
    empty_fifo_D0 = 1'b1;
    empty_fifo_D1 = 1'b1;
    data_out_D0   = '0;
    data_out_D1   = '0;
    model_clear();
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_src", src_out, 0);
    chk("rst_cnt_D0", cnt_D0, 0);
    chk("rst_cnt_D1", cnt_D1, 0);
    chk("rst_D0_pop", D0_pop, 0);
    chk("rst_D1_pop", D1_pop, 0);
    reset      = 1'b0;
    active_in  = 1'b1;
    sink_ready = 1'b1;
    cycle();
    chk("rst_idle", idle_out, 1);

    // single word latency
    push0(6'b000100);
    #1;
    chk("t1_pop", D0_pop, 1);
    cycle();
    chk("t1_valid_n1", valid_out, 0);
    cycle();
    chk("t1_valid_n2", valid_out, 1);
    chk("t1_data", data_out, 6'b000100);
    chk("t1_src", src_out, 0);
    cycle();
    cycle();
    chk("t1_cnt_D0", cnt_D0, 1);
    chk("t1_idle", idle_out, 1);

    // round robin
    do_reset();
    clear_logs();
    push0(6'h05); push0(6'h36);
    push1(6'h0E); push1(6'h22);
    drain(50);
    exp_rr = '{7'h05, 7'h4E, 7'h36, 7'h62};
    chk("rr_pop_count", pop_log.size(), 4);
    chk("rr_deliv_count", deliv_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size())   chk("rr_pop_order", pop_log[i], i % 2);
      if (i < deliv_log.size()) chk("rr_deliv", deliv_log[i], exp_rr[i]);
    end
    chk("rr_cnt_D0", cnt_D0, 2);
    chk("rr_cnt_D1", cnt_D1, 2);

    // backpressure
    do_reset();
    clear_logs();
    sink_ready = 1'b0;
    push1(6'h11); push1(6'h2A); push1(6'h3F); push1(6'h01);
    repeat (8) cycle();
    chk("bp_pops", pop_log.size(), 2);
    chk("bp_valid", valid_out, 1);
    chk("bp_head", {src_out, data_out}, 7'h51);
    chk("bp_idle", idle_out, 0);
    drain(50);
    exp_bp = '{7'h51, 7'h6A, 7'h7F, 7'h41};
    chk("bp_deliv_count", deliv_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < deliv_log.size()) chk("bp_deliv", deliv_log[i], exp_bp[i]);

    // gating
    do_reset();
    clear_logs();
    active_in = 1'b0;
    push0(6'h07); push0(6'h19);
    push1(6'h2C); push1(6'h30);
    repeat (5) cycle();
    chk("gate_no_pops", pop_log.size(), 0);
    chk("gate_idle", idle_out, 1);
    active_in = 1'b1;
    cycle();
    active_in = 1'b0;
    repeat (6) cycle();
    chk("gate_one_pop", pop_log.size(), 1);
    chk("gate_deliv_count", deliv_log.size(), 1);
    if (deliv_log.size() != 0) chk("gate_deliv", deliv_log[0], 7'h07);
    chk("gate_idle_after", idle_out, 1);
    drain(50);

    // counter wrap
    do_reset();
    for (int i = 0; i < 257; i++) push0(6'($urandom));
    drain(1000);
    chk("wrap_cnt_D0", cnt_D0, 1);
    chk("wrap_cnt_D1", cnt_D1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) push0(6'($urandom));
      if ($urandom_range(0, 2) == 0) push1(6'($urandom));
      active_in  = ($urandom_range(0, 7) != 0);
      sink_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(2000);
    chk("rand_cnt_D0", cnt_D0, mcnt0);
    chk("rand_cnt_D1", cnt_D1, mcnt1);

    // reset mid-stream
    sink_ready = 1'b0;
    active_in  = 1'b1;
    push0(6'h0A); push0(6'h0B); push0(6'h0C); push0(6'h0D);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_cnt_D0", cnt_D0, 0);
    chk("mid_rst_cnt_D1", cnt_D1, 0);
    chk("mid_rst_D0_pop", D0_pop, 0);
    chk("mid_rst_D1_pop", D1_pop, 0);
    chk("mid_rst_idle", idle_out, 1);
    reset = 1'b0;
    clear_logs();
    drain(50);
    chk("mid_rst_deliv_count", deliv_log.size(), 2);
    if (deliv_log.size() == 2) begin
      chk("mid_rst_deliv0", deliv_log[0], 7'h0C);
      chk("mid_rst_deliv1", deliv_log[1], 7'h0D);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
